// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the two-client internal-memory arbiter.
// Optional build macro used by the top level: IMEM_ARB_STATS_EN.
package imem_arb_pkg;

    localparam logic       CMD_READ  = 1'b1;
    localparam logic       CMD_WRITE = 1'b0;
    localparam logic       CLIENT_A  = 1'b0;
    localparam logic       CLIENT_B  = 1'b1;
    localparam logic [7:0] BE_NONE   = 8'hFF;

    typedef struct packed {
        logic        cmd;
        logic [15:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
    } imem_req_t;

    // Reads never write, so they go out with every byte disabled (active-low).
    function automatic logic [7:0] issue_be(input imem_req_t req);
        return (req.cmd == CMD_READ) ? BE_NONE : req.be;
    endfunction

endpackage

// File: rtl/imem_req_buffer.sv
// One-entry request holding register for a single arbiter client.
// Load wins over drain so a granted entry can be refilled at the same edge.
module imem_req_buffer
    import imem_arb_pkg::*;
#(
    parameter int TagWidth = 20
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                i_load,
    input  logic                i_drain,
    input  logic                i_cmd,
    input  logic [15:0]         i_addr,
    input  logic [7:0]          i_be,
    input  logic [63:0]         i_data,
    input  logic [TagWidth-1:0] i_tag,
    output logic                o_valid,
    output logic                o_cmd,
    output logic [15:0]         o_addr,
    output logic [7:0]          o_be,
    output logic [63:0]         o_data,
    output logic [TagWidth-1:0] o_tag
);

    logic                r_valid;
    imem_req_t           r_req;
    logic [TagWidth-1:0] r_tag;

    // Occupancy: set on load, cleared when drained without a refill.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    // Payload capture on every accepted request.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_req <= '0;
            r_tag <= '0;
        end else if (i_load) begin
            r_req <= '{cmd: i_cmd, addr: i_addr, be: i_be, data: i_data};
            r_tag <= i_tag;
        end
    end

    assign o_valid = r_valid;
    assign o_cmd   = r_req.cmd;
    assign o_addr  = r_req.addr;
    assign o_be    = r_req.be;
    assign o_data  = r_req.data;
    assign o_tag   = r_tag;

endmodule

// File: rtl/imem_port_arbiter.sv
// Two-client round-robin front end for the 64-bit internal memory port.
// Client ID travels in the MSB of the memory tag and steers read responses.
// Build macro IMEM_ARB_STATS_EN adds GRANTA/GRANTB/CONFLICTS counters.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int TagWidth = 20
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                AACT,
    input  logic                ACMD,
    input  logic [15:0]         AADDR,
    input  logic [7:0]          ABE,
    input  logic [63:0]         ADI,
    input  logic [TagWidth-1:0] ATAG,
    output logic                ANEXT,
    output logic                ADRDY,
    output logic [63:0]         ADO,
    output logic [TagWidth-1:0] ATO,
    input  logic                BACT,
    input  logic                BCMD,
    input  logic [15:0]         BADDR,
    input  logic [7:0]          BBE,
    input  logic [63:0]         BDI,
    input  logic [TagWidth-1:0] BTAG,
    output logic                BNEXT,
    output logic                BDRDY,
    output logic [63:0]         BDO,
    output logic [TagWidth-1:0] BTO,
    output logic                MACT,
    output logic                MCMD,
    output logic [15:0]         MADDR,
    output logic [7:0]          MBE,
    output logic [63:0]         MDI,
    output logic [TagWidth:0]   MTI,
    input  logic                MDRDY,
    input  logic [63:0]         MDO,
    input  logic [TagWidth:0]   MTO
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [31:0]         GRANTA,
    output logic [31:0]         GRANTB,
    output logic [31:0]         CONFLICTS
`endif
);

    logic                w_valid_a, w_valid_b;
    logic                w_cmd_a, w_cmd_b;
    logic [15:0]         w_addr_a, w_addr_b;
    logic [7:0]          w_be_a, w_be_b;
    logic [63:0]         w_data_a, w_data_b;
    logic [TagWidth-1:0] w_tag_a, w_tag_b;
    imem_req_t           w_req_a, w_req_b;

    logic                w_grant_a, w_grant_b, w_grant_any, w_conflict;
    logic                w_load_a, w_load_b;
    imem_req_t           w_sel_req;
    logic [TagWidth-1:0] w_sel_tag;
    logic                w_sel_id;
    logic                w_rsp_valid, w_rsp_a, w_rsp_b;

    logic                r_ptr;
    logic                r_flush;
    logic                r_mact, r_mcmd;
    logic [15:0]         r_maddr;
    logic [7:0]          r_mbe;
    logic [63:0]         r_mdi;
    logic [TagWidth:0]   r_mti;
    logic                r_adrdy, r_bdrdy;
    logic [63:0]         r_ado, r_bdo;
    logic [TagWidth-1:0] r_ato, r_bto;

    imem_req_buffer #(.TagWidth(TagWidth)) u_buf_a (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .i_load  (w_load_a),
        .i_drain (w_grant_a),
        .i_cmd   (ACMD),
        .i_addr  (AADDR),
        .i_be    (ABE),
        .i_data  (ADI),
        .i_tag   (ATAG),
        .o_valid (w_valid_a),
        .o_cmd   (w_cmd_a),
        .o_addr  (w_addr_a),
        .o_be    (w_be_a),
        .o_data  (w_data_a),
        .o_tag   (w_tag_a)
    );

    imem_req_buffer #(.TagWidth(TagWidth)) u_buf_b (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .i_load  (w_load_b),
        .i_drain (w_grant_b),
        .i_cmd   (BCMD),
        .i_addr  (BADDR),
        .i_be    (BBE),
        .i_data  (BDI),
        .i_tag   (BTAG),
        .o_valid (w_valid_b),
        .o_cmd   (w_cmd_b),
        .o_addr  (w_addr_b),
        .o_be    (w_be_b),
        .o_data  (w_data_b),
        .o_tag   (w_tag_b)
    );

    assign w_req_a = '{cmd: w_cmd_a, addr: w_addr_a, be: w_be_a, data: w_data_a};
    assign w_req_b = '{cmd: w_cmd_b, addr: w_addr_b, be: w_be_b, data: w_data_b};

    // Round-robin grant: the pointer only matters when both buffers hold a request.
    assign w_conflict  = w_valid_a & w_valid_b;
    assign w_grant_a   = w_valid_a & (~w_valid_b | (r_ptr == CLIENT_A));
    assign w_grant_b   = w_valid_b & (~w_valid_a | (r_ptr == CLIENT_B));
    assign w_grant_any = w_grant_a | w_grant_b;

    // Valid/ready handshake: a request transfers on any rising edge where
    // xACT and xNEXT are both high; xNEXT depends only on buffer state.
    assign ANEXT    = ~w_valid_a | w_grant_a;
    assign BNEXT    = ~w_valid_b | w_grant_b;
    assign w_load_a = AACT & ANEXT;
    assign w_load_b = BACT & BNEXT;

    // Select the granted buffer's request for the issue register.
    always_comb begin
        w_sel_req = w_req_a;
        w_sel_tag = w_tag_a;
        w_sel_id  = CLIENT_A;
        if (w_grant_b) begin
            w_sel_req = w_req_b;
            w_sel_tag = w_tag_b;
            w_sel_id  = CLIENT_B;
        end
    end

    // Pointer hands priority to the loser after every conflict.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_ptr <= CLIENT_A;
        end else if (w_conflict) begin
            r_ptr <= ~r_ptr;
        end
    end

    // Issue register: one-cycle strobe per grant; address/data hold when idle.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_mact  <= 1'b0;
            r_mcmd  <= 1'b0;
            r_maddr <= '0;
            r_mbe   <= BE_NONE;
            r_mdi   <= '0;
            r_mti   <= '0;
        end else begin
            r_mact <= w_grant_any;
            if (w_grant_any) begin
                r_mcmd  <= w_sel_req.cmd;
                r_maddr <= w_sel_req.addr;
                r_mbe   <= issue_be(w_sel_req);
                r_mdi   <= w_sel_req.data;
                r_mti   <= {w_sel_id, w_sel_tag};
            end
        end
    end

    // The memory is not reset, so its first post-reset MDRDY is untrusted.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_flush <= 1'b1;
        end else begin
            r_flush <= 1'b0;
        end
    end

    assign w_rsp_valid = MDRDY & ~r_flush;
    assign w_rsp_a     = w_rsp_valid & (MTO[TagWidth] == CLIENT_A);
    assign w_rsp_b     = w_rsp_valid & (MTO[TagWidth] == CLIENT_B);

    // Response routing: strobe for one cycle, data/tag hold between responses.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_adrdy <= 1'b0;
            r_bdrdy <= 1'b0;
            r_ado   <= '0;
            r_bdo   <= '0;
            r_ato   <= '0;
            r_bto   <= '0;
        end else begin
            r_adrdy <= w_rsp_a;
            r_bdrdy <= w_rsp_b;
            if (w_rsp_a) begin
                r_ado <= MDO;
                r_ato <= MTO[TagWidth-1:0];
            end
            if (w_rsp_b) begin
                r_bdo <= MDO;
                r_bto <= MTO[TagWidth-1:0];
            end
        end
    end

    assign MACT  = r_mact;
    assign MCMD  = r_mcmd;
    assign MADDR = r_maddr;
    assign MBE   = r_mbe;
    assign MDI   = r_mdi;
    assign MTI   = r_mti;
    assign ADRDY = r_adrdy;
    assign ADO   = r_ado;
    assign ATO   = r_ato;
    assign BDRDY = r_bdrdy;
    assign BDO   = r_bdo;
    assign BTO   = r_bto;

`ifdef IMEM_ARB_STATS_EN
    logic [31:0] r_granta, r_grantb, r_conflicts;

    // Free-running wrap-around grant and conflict counters.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_granta    <= '0;
            r_grantb    <= '0;
            r_conflicts <= '0;
        end else begin
            if (w_grant_a)  r_granta    <= r_granta + 32'd1;
            if (w_grant_b)  r_grantb    <= r_grantb + 32'd1;
            if (w_conflict) r_conflicts <= r_conflicts + 32'd1;
        end
    end

    assign GRANTA    = r_granta;
    assign GRANTB    = r_grantb;
    assign CONFLICTS = r_conflicts;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 1-cycle memory
// and per-client expected-response queues.
module tb_imem_port_arbiter;

  localparam int TW = 20;
  localparam int EW = TW + 64;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          AACT, ACMD, BACT, BCMD;
  logic [15:0]   AADDR, BADDR;
  logic [7:0]    ABE, BBE;
  logic [63:0]   ADI, BDI;
  logic [TW-1:0] ATAG, BTAG;
  logic          ANEXT, ADRDY, BNEXT, BDRDY;
  logic [63:0]   ADO, BDO;
  logic [TW-1:0] ATO, BTO;
  logic          MACT, MCMD;
  logic [15:0]   MADDR;
  logic [7:0]    MBE;
  logic [63:0]   MDI;
  logic [TW:0]   MTI;
  logic          MDRDY;
  logic [63:0]   MDO;
  logic [TW:0]   MTO;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0]   GRANTA, GRANTB, CONFLICTS;
`endif

  imem_port_arbiter #(.TagWidth(TW)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .AACT(AACT), .ACMD(ACMD), .AADDR(AADDR), .ABE(ABE), .ADI(ADI), .ATAG(ATAG),
    .ANEXT(ANEXT), .ADRDY(ADRDY), .ADO(ADO), .ATO(ATO),
    .BACT(BACT), .BCMD(BCMD), .BADDR(BADDR), .BBE(BBE), .BDI(BDI), .BTAG(BTAG),
    .BNEXT(BNEXT), .BDRDY(BDRDY), .BDO(BDO), .BTO(BTO),
    .MACT(MACT), .MCMD(MCMD), .MADDR(MADDR), .MBE(MBE), .MDI(MDI), .MTI(MTI),
    .MDRDY(MDRDY), .MDO(MDO), .MTO(MTO)
`ifdef IMEM_ARB_STATS_EN
    , .GRANTA(GRANTA), .GRANTB(GRANTB), .CONFLICTS(CONFLICTS)
`endif
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- memory model ----------------
  logic [63:0] mem [0:255];
  logic [63:0] ref_mem [0:255];
  logic        mem_rdy = 1'b0;
  logic [63:0] mem_do = '0;
  logic [TW:0] mem_to = '0;
  logic        junk = 1'b0;

  assign MDRDY = mem_rdy | junk;
  assign MDO   = mem_do;
  assign MTO   = mem_to;

  always @(posedge CLK) begin
    mem_rdy <= MACT & MCMD;
    if (MACT && MCMD) begin
      mem_do <= mem[MADDR[7:0]];
      mem_to <= MTI;
    end
    if (MACT && !MCMD) begin
      for (int i = 0; i < 8; i++)
        if (!MBE[i]) mem[MADDR[7:0]][8*i +: 8] = MDI[8*i +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (ADRDY === 1'b1) begin
      if (exp_a_q.size() == 0) check("a_unexpected_drdy", ADRDY, 0);
      else check("a_resp", {ATO, ADO}, exp_a_q.pop_front());
    end
    if (BDRDY === 1'b1) begin
      if (exp_b_q.size() == 0) check("b_unexpected_drdy", BDRDY, 0);
      else check("b_resp", {BTO, BDO}, exp_b_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept(input bit cl, input logic cmd, input logic [15:0] addr,
                        input logic [7:0] be, input logic [63:0] di, input logic [TW-1:0] tag);
    if (cmd) begin
      if (cl) exp_b_q.push_back({tag, ref_mem[addr[7:0]]});
      else    exp_a_q.push_back({tag, ref_mem[addr[7:0]]});
    end else begin
      for (int i = 0; i < 8; i++)
        if (!be[i]) ref_mem[addr[7:0]][8*i +: 8] = di[8*i +: 8];
    end
  endtask

  task automatic tick();
    if (AACT && ANEXT) accept(1'b0, ACMD, AADDR, ABE, ADI, ATAG);
    if (BACT && BNEXT) accept(1'b1, BCMD, BADDR, BBE, BDI, BTAG);
    @(negedge CLK);
  endtask

  task automatic set_a(input logic cmd, input logic [15:0] addr, input logic [7:0] be,
                       input logic [63:0] di, input logic [TW-1:0] tag);
    AACT = 1'b1; ACMD = cmd; AADDR = addr; ABE = be; ADI = di; ATAG = tag;
  endtask

  task automatic set_b(input logic cmd, input logic [15:0] addr, input logic [7:0] be,
                       input logic [63:0] di, input logic [TW-1:0] tag);
    BACT = 1'b1; BCMD = cmd; BADDR = addr; BBE = be; BDI = di; BTAG = tag;
  endtask

  task automatic idle_a(); AACT = 1'b0; endtask
  task automatic idle_b(); BACT = 1'b0; endtask

  task automatic reset_checks();
    check("rst_mact", MACT, 0);
    check("rst_mcmd", MCMD, 0);
    check("rst_maddr", MADDR, 0);
    check("rst_mbe", MBE, 8'hFF);
    check("rst_mdi", MDI, 0);
    check("rst_mti", MTI, 0);
    check("rst_adrdy", ADRDY, 0);
    check("rst_bdrdy", BDRDY, 0);
    check("rst_ado", ADO, 0);
    check("rst_bdo", BDO, 0);
    check("rst_ato", ATO, 0);
    check("rst_bto", BTO, 0);
    check("rst_anext", ANEXT, 1);
    check("rst_bnext", BNEXT, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic par;
    logic npar;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      mem[i]     = {16'hCAFE, 8'h00, b, 16'h0BAD, 8'h00, b};
      ref_mem[i] = {16'hCAFE, 8'h00, b, 16'h0BAD, 8'h00, b};
    end
    AACT = 0; ACMD = 0; AADDR = 0; ABE = 8'hFF; ADI = 0; ATAG = 0;
    BACT = 0; BCMD = 0; BADDR = 0; BBE = 8'hFF; BDI = 0; BTAG = 0;

    repeat (2) @(negedge CLK);
    reset_checks();
    RESETn = 1'b1;
    @(negedge CLK);

    // Partial write then read-back with latency checks.
    set_a(1'b0, 16'h0010, 8'hF0, 64'h1122334455667788, 20'h00001);
    tick();
    idle_a();
    check("wr_mact_early", MACT, 0);
    tick();
    check("wr_mact", MACT, 1);
    check("wr_mcmd", MCMD, 0);
    check("wr_maddr", MADDR, 16'h0010);
    check("wr_mbe", MBE, 8'hF0);
    check("wr_mdi", MDI, 64'h1122334455667788);
    check("wr_mti", MTI, {1'b0, 20'h00001});
    set_a(1'b1, 16'h0010, 8'h00, 64'h0, 20'h0BEEF);
    tick();
    idle_a();
    check("rd_mact_early", MACT, 0);
    tick();
    check("rd_mact", MACT, 1);
    check("rd_mbe_forced", MBE, 8'hFF);
    check("rd_mti", MTI, {1'b0, 20'h0BEEF});
    tick();
    check("rd_adrdy_early", ADRDY, 0);
    tick();
    check("rd_adrdy", ADRDY, 1);
    check("rd_ado_lo", ADO[31:0], 32'h55667788);
    check("rd_ado_hi", ADO[63:32], 32'hCAFE0010);
    check("rd_ato", ATO, 20'h0BEEF);
    repeat (2) tick();

    // Dual streaming reads: A and B alternate on the memory port.
    for (int k = 0; k < 8; k++) begin
      par  = k[0];
      npar = !par;
      if (k >= 1) begin
        check("stream_anext", ANEXT, par);
        check("stream_bnext", BNEXT, npar);
      end
      if (k >= 2) begin
        check("stream_mact", MACT, 1);
        check("stream_mti_id", MTI[TW], par);
      end
      set_a(1'b1, 16'h0020 + 16'(k), 8'hFF, 64'h0, 20'h00100 + 20'(k));
      set_b(1'b1, 16'h0040 + 16'(k), 8'hFF, 64'h0, 20'h00200 + 20'(k));
      tick();
    end
    idle_a();
    idle_b();
    repeat (6) tick();
    check("stream_a_drained", exp_a_q.size(), 0);
    check("stream_b_drained", exp_b_q.size(), 0);

    // Simultaneous reads: A first, B one cycle later.
    set_a(1'b1, 16'h0030, 8'hFF, 64'h0, 20'hABCDE);
    set_b(1'b1, 16'h0050, 8'hFF, 64'h0, 20'h12345);
    tick();
    idle_a();
    idle_b();
    repeat (3) tick();
    check("pair_adrdy", ADRDY, 1);
    check("pair_bdrdy_quiet", BDRDY, 0);
    check("pair_ato", ATO, 20'hABCDE);
    tick();
    check("pair_adrdy_done", ADRDY, 0);
    check("pair_bdrdy", BDRDY, 1);
    check("pair_bto", BTO, 20'h12345);
    repeat (2) tick();

    // Reset with a read in flight, garbage MDRDY on the first cycle after release.
    set_a(1'b1, 16'h0011, 8'hFF, 64'h0, 20'h00777);
    tick();
    idle_a();
    tick();
    check("mid_mact", MACT, 1);
    RESETn = 1'b0;
    #1;
    exp_a_q.delete();
    exp_b_q.delete();
    reset_checks();
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    junk = 1'b1;
    @(negedge CLK);
    junk = 1'b0;
    check("flush_adrdy", ADRDY, 0);
    check("flush_bdrdy", BDRDY, 0);
    repeat (3) tick();
    set_a(1'b1, 16'h0010, 8'hFF, 64'h0, 20'h04242);
    tick();
    idle_a();
    repeat (3) tick();
    check("post_rst_adrdy", ADRDY, 1);
    check("post_rst_ado", ADO, {32'hCAFE0010, 32'h55667788});
    repeat (2) tick();

    // Write with all bytes disabled: strobe only, memory untouched, no response.
    set_b(1'b0, 16'h0012, 8'hFF, 64'hDEADBEEFDEADBEEF, 20'h00055);
    tick();
    idle_b();
    tick();
    check("nowr_mact", MACT, 1);
    check("nowr_mcmd", MCMD, 0);
    check("nowr_mbe", MBE, 8'hFF);
    check("nowr_mti", MTI, {1'b1, 20'h00055});
    repeat (3) tick();
    check("nowr_mem", mem[8'h12], 64'hCAFE00120BAD0012);
    check("nowr_bdrdy", BDRDY, 0);

`ifdef IMEM_ARB_STATS_EN
    // Counters after ten grant edges of dual streaming from reset.
    RESETn = 1'b0;
    #1;
    check("stats_rst_granta", GRANTA, 0);
    check("stats_rst_conflicts", CONFLICTS, 0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 11; k++) begin
      set_a(1'b1, 16'h0060 + 16'(k), 8'hFF, 64'h0, 20'h00300 + 20'(k));
      set_b(1'b1, 16'h0080 + 16'(k), 8'hFF, 64'h0, 20'h00400 + 20'(k));
      tick();
    end
    check("stats_granta", GRANTA, 32'd5);
    check("stats_grantb", GRANTB, 32'd5);
    check("stats_conflicts_min", CONFLICTS >= 32'd9, 1);
    idle_a();
    idle_b();
    repeat (6) tick();
`endif

    repeat (4) tick();
    check("final_a_drained", exp_a_q.size(), 0);
    check("final_b_drained", exp_b_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
